prog_loader: RTL and testbench

Upstream feeder for the TIS core array. It accepts a word stream of per-core program frames over a valid/ready handshake and stores each program in a per-core instruction bank. It drives every core's prog and pLength inputs. It holds the cores in reset until an end-of-load command arrives, then releases them together.

---
 rtl/tis_pkg.sv | 27 ++
 rtl/prog_bank.sv | 59 +++++
 rtl/prog_loader.sv | 141 ++++++++++++++
 tb/tb_prog_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tis_pkg.sv
// Shared definitions for the TIS program loader.
//   instr_t            : one instruction / stream word
//   DEFAULT_PROG_DEPTH : instruction slots per core (fits the 4-bit length field)
//   IDX_*/LEN_*        : header field positions
//   END_IDX            : header core index that ends loading
//   ldr_state_t        : loader FSM states
package tis_pkg;

  typedef logic [15:0] instr_t;

  localparam int DEFAULT_PROG_DEPTH = 15;

  localparam int IDX_MSB = 15;
  localparam int IDX_LSB = 8;
  localparam int LEN_MSB = 3;
  localparam int LEN_LSB = 0;

  localparam logic [7:0] END_IDX = 8'hFF;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    DATA = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } ldr_state_t;

endpackage

// File: rtl/prog_bank.sv
// One core's instruction bank: DEPTH instruction registers plus a 4-bit pLength.
// Ports:
//   clk, rst   : clock, synchronous active-low reset
//   clr        : zero every slot (wins over we in the same cycle)
//   len_we/len : load pLength
//   we/addr/wdata : write one slot
//   bank       : all slots flattened, slot s at bits [s*W +: W]
//   plen       : current pLength
module prog_bank
  import tis_pkg::*;
#(
  parameter int DEPTH = DEFAULT_PROG_DEPTH,
  parameter int W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               len_we,
  input  logic [3:0]         len,
  input  logic               we,
  input  logic [3:0]         addr,
  input  logic [W-1:0]       wdata,
  output logic [DEPTH*W-1:0] bank,
  output logic [3:0]         plen
);

  logic [W-1:0] slot_q [DEPTH];
  logic [W-1:0] slot_d [DEPTH];
  logic [3:0]   plen_q;
  logic [3:0]   plen_d;

  always_comb begin
    slot_d = slot_q;
    plen_d = plen_q;
    if (clr) begin
      for (int s = 0; s < DEPTH; s++) slot_d[s] = '0;
    end else if (we && (32'(addr) < DEPTH)) begin
      slot_d[addr] = wdata;
    end
    if (len_we) plen_d = len;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < DEPTH; s++) slot_q[s] <= '0;
      plen_q <= '0;
    end else begin
      slot_q <= slot_d;
      plen_q <= plen_d;
    end
  end

  for (genvar s = 0; s < DEPTH; s++) begin : g_flat
    assign bank[s*W +: W] = slot_q[s];
  end

  assign plen = plen_q;

endmodule

// File: rtl/prog_loader.sv
// Stream loader for the TIS core array: parses per-core program frames from a
// valid/ready word stream into per-core banks, then releases the cores.
// Ports:
//   clk, rst  : clock, synchronous active-low reset
//   in_data/in_valid/in_ready : word stream (header or instruction)
//   prog_flat : all banks, core c slot s at word index c*PROG_DEPTH+s
//   plen_flat : pLength per core, core c at [4c+3:4c]
//   loaded    : core has received a frame since reset
//   core_rst  : active-high reset to the core array
//   err       : sticky protocol error
//
// state | meaning
// HDR   | waiting for a header (or END)
// DATA  | receiving instruction words for the latched core
// DONE  | loading finished, cores released, stream closed
// ERR   | bad header seen, cores held in reset, stream closed
module prog_loader
  import tis_pkg::*;
#(
  parameter int NUM_CORES  = 12,
  parameter int PROG_DEPTH = DEFAULT_PROG_DEPTH,
  parameter int WORD_W     = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [WORD_W-1:0]                 in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [NUM_CORES*PROG_DEPTH*WORD_W-1:0] prog_flat,
  output logic [NUM_CORES*4-1:0]            plen_flat,
  output logic [NUM_CORES-1:0]              loaded,
  output logic                              core_rst,
  output logic                              err
);

  localparam int BANK_W = PROG_DEPTH * WORD_W;

  ldr_state_t           state_q, state_d;
  logic [3:0]           wptr_q, wptr_d;
  logic [7:0]           idx_q, idx_d;
  logic [3:0]           len_q, len_d;
  logic [NUM_CORES-1:0] loaded_q, loaded_d;

  logic [7:0] hdr_idx;
  logic [3:0] hdr_len;
  logic       idx_bad;
  logic       len_bad;
  logic       hdr_load;
  logic       data_we;
  logic       unused_hdr_bits;

  assign hdr_idx = in_data[IDX_MSB:IDX_LSB];
  assign hdr_len = in_data[LEN_MSB:LEN_LSB];
  assign unused_hdr_bits = ^in_data[7:4];

  assign idx_bad = 32'(hdr_idx) >= NUM_CORES;
  assign len_bad = 32'(hdr_len) > PROG_DEPTH;

  assign hdr_load = (state_q == HDR) && in_valid && (hdr_idx != END_IDX) && !idx_bad && !len_bad;
  assign data_we  = (state_q == DATA) && in_valid;

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    idx_d    = idx_q;
    len_d    = len_q;
    loaded_d = loaded_q;
    unique case (state_q)
      HDR: begin
        if (in_valid) begin
          if (hdr_idx == END_IDX) begin
            state_d = DONE;
          end else if (idx_bad || len_bad) begin
            state_d = ERR;
          end else begin
            idx_d  = hdr_idx;
            len_d  = hdr_len;
            wptr_d = '0;
            // a zero-length frame only clears the bank; stay ready for a header
            if (hdr_len != 4'd0) state_d = DATA;
          end
        end
      end
      DATA: begin
        if (in_valid) begin
          if (wptr_q == len_q - 4'd1) begin
            wptr_d  = '0;
            state_d = HDR;
          end else begin
            wptr_d = wptr_q + 4'd1;
          end
        end
      end
      default: ;
    endcase
    for (int c = 0; c < NUM_CORES; c++) begin
      if (hdr_load && (hdr_idx == 8'(c))) loaded_d[c] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= HDR;
      wptr_q   <= '0;
      idx_q    <= '0;
      len_q    <= '0;
      loaded_q <= '0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      loaded_q <= loaded_d;
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_bank
    prog_bank #(
      .DEPTH (PROG_DEPTH),
      .W     (WORD_W)
    ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .clr    (hdr_load && (hdr_idx == 8'(g))),
      .len_we (hdr_load && (hdr_idx == 8'(g))),
      .len    (hdr_len),
      .we     (data_we && (idx_q == 8'(g))),
      .addr   (wptr_q),
      .wdata  (in_data),
      .bank   (prog_flat[g*BANK_W +: BANK_W]),
      .plen   (plen_flat[g*4 +: 4])
    );
  end

  // Handshake and core control depend on state only.
  assign in_ready = (state_q == HDR) || (state_q == DATA);
  assign core_rst = (state_q != DONE);
  assign err      = (state_q == ERR);
  assign loaded   = loaded_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  localparam int NC = 12;
  localparam int PD = 15;
  localparam int W  = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [W-1:0]        in_data = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [NC*PD*W-1:0]  prog_flat;
  logic [NC*4-1:0]     plen_flat;
  logic [NC-1:0]       loaded;
  logic                core_rst;
  logic                err;

  int total = 0;
  int bad   = 0;

  prog_loader #(.NUM_CORES(NC), .PROG_DEPTH(PD), .WORD_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prog_flat (prog_flat),
    .plen_flat (plen_flat),
    .loaded    (loaded),
    .core_rst  (core_rst),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Stream-level reference: a parser that knows how many instruction words
  // are still owed to the current frame.
  logic [W-1:0]  m_prog [NC][PD];
  logic [3:0]    m_len  [NC];
  logic [NC-1:0] m_loaded;
  bit            m_done, m_err;
  int            m_core, m_left;

  task automatic model_clear();
    for (int c = 0; c < NC; c++) begin
      for (int s = 0; s < PD; s++) m_prog[c][s] = '0;
      m_len[c] = '0;
    end
    m_loaded = '0; m_done = 0; m_err = 0; m_core = 0; m_left = 0;
  endtask

  task automatic model_accept(input logic [W-1:0] w);
    int idx, l;
    if (m_done || m_err) return;
    if (m_left > 0) begin
      m_prog[m_core][int'(m_len[m_core]) - m_left] = w;
      m_left--;
    end else begin
      idx = int'(w[15:8]);
      l   = int'(w[3:0]);
      if (idx == 255) m_done = 1;
      else if (idx >= NC || l > PD) m_err = 1;
      else begin
        for (int s = 0; s < PD; s++) m_prog[idx][s] = '0;
        m_len[idx] = w[3:0];
        m_loaded[idx] = 1'b1;
        m_core = idx;
        m_left = l;
      end
    end
  endtask

  function automatic int prog_diff();
    for (int i = 0; i < NC*PD; i++)
      if (prog_flat[i*W +: W] !== m_prog[i/PD][i%PD]) return i;
    return -1;
  endfunction

  function automatic logic [NC*4-1:0] exp_plen();
    logic [NC*4-1:0] r;
    for (int c = 0; c < NC; c++) r[c*4 +: 4] = m_len[c];
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      in_valid = 1'($urandom);
      in_data  = W'($urandom);
      @(negedge clk);
    end
    rst = 1'b1;
    in_valid = 1'b0;
    model_clear();
  endtask

  // Returns #1 after the accepting edge, when registered outputs have settled.
  task automatic push(input logic [W-1:0] w, input int gap);
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = W'($urandom);
    end
    @(negedge clk);
    in_data  = w;
    in_valid = 1'b1;
    @(posedge clk);
    model_accept(w);
    #1 in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (prog_flat !== '0) begin bad++; $display("FAIL reset prog not all zero"); end
    total++; if (plen_flat !== '0) begin bad++; $display("FAIL reset plen got %h exp 0", plen_flat); end
    total++; if (loaded !== '0) begin bad++; $display("FAIL reset loaded got %h exp 0", loaded); end
    total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL reset core_rst got %b exp 1", core_rst); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset err got %b exp 0", err); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_basic();
    int d;
    do_reset();
    push(16'h0003, 0); push(16'h1111, 0); push(16'h2222, 0); push(16'h3333, 0);
    total++; if (prog_flat[0 +: 3*W] !== {16'h3333, 16'h2222, 16'h1111}) begin bad++; $display("FAIL basic slots0_2 got %h exp 333322221111", prog_flat[0 +: 3*W]); end
    total++; if (prog_flat[3*W +: 12*W] !== '0) begin bad++; $display("FAIL basic slots3_14 not zero"); end
    total++; if (plen_flat[3:0] !== 4'd3) begin bad++; $display("FAIL basic plen0 got %0d exp 3", plen_flat[3:0]); end
    total++; if (loaded !== 12'h001) begin bad++; $display("FAIL basic loaded got %h exp 001", loaded); end
    @(negedge clk);
    in_data = 16'hFF00; in_valid = 1'b1;
    total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL basic core_rst_before_end got %b exp 1", core_rst); end
    @(posedge clk); model_accept(16'hFF00); #1 in_valid = 1'b0;
    total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL basic core_rst_after_end got %b exp 0", core_rst); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic in_ready_after_end got %b exp 0", in_ready); end
    push(16'h0001, 0); push(16'hBEEF, 0);
    total++; d = prog_diff(); if (d >= 0) begin bad++; $display("FAIL basic_closed prog word %0d got %h exp %h", d, prog_flat[d*W +: W], m_prog[d/PD][d%PD]); end
    total++; if (loaded !== m_loaded) begin bad++; $display("FAIL basic_closed loaded got %h exp %h", loaded, m_loaded); end
  endtask

  task automatic test_zero_len();
    int d;
    do_reset();
    push(16'h0100, 0);
    total++; if (loaded !== 12'h002) begin bad++; $display("FAIL zero_len loaded got %h exp 002", loaded); end
    total++; if (plen_flat[7:4] !== 4'd0) begin bad++; $display("FAIL zero_len plen1 got %0d exp 0", plen_flat[7:4]); end
    // the next word must be parsed as a header, not as data for core 1
    push(16'h0501, 0); push(16'h5555, 0); push(16'hFF00, 0);
    total++; d = prog_diff(); if (d >= 0) begin bad++; $display("FAIL zero_len prog word %0d got %h exp %h", d, prog_flat[d*W +: W], m_prog[d/PD][d%PD]); end
    total++; if (loaded !== m_loaded) begin bad++; $display("FAIL zero_len loaded_final got %h exp %h", loaded, m_loaded); end
    total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL zero_len core_rst got %b exp 0", core_rst); end
  endtask

  task automatic test_reload();
    int d;
    do_reset();
    push(16'h0204, 0);
    push(16'hAAAA, 0); push(16'hBBBB, 0); push(16'hCCCC, 0); push(16'hDDDD, 0);
    push(16'h0202, 1); push(16'hEEEE, 0); push(16'hFFFF, 0); push(16'hFF00, 0);
    total++; if (prog_flat[2*PD*W +: PD*W] !== {{13{16'h0000}}, 16'hFFFF, 16'hEEEE}) begin bad++; $display("FAIL reload bank2 got %h", prog_flat[2*PD*W +: PD*W]); end
    total++; if (plen_flat[11:8] !== 4'd2) begin bad++; $display("FAIL reload plen2 got %0d exp 2", plen_flat[11:8]); end
    total++; d = prog_diff(); if (d >= 0) begin bad++; $display("FAIL reload prog word %0d got %h exp %h", d, prog_flat[d*W +: W], m_prog[d/PD][d%PD]); end
  endtask

  task automatic test_err_idx();
    do_reset();
    push(16'h0C01, 0);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_idx err got %b exp 1", err); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL err_idx in_ready got %b exp 0", in_ready); end
    total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL err_idx core_rst got %b exp 1", core_rst); end
    push(16'h0001, 0); push(16'h1234, 0); push(16'hFF00, 0);
    total++; if (loaded !== '0) begin bad++; $display("FAIL err_idx loaded got %h exp 0", loaded); end
    total++; if (prog_flat !== '0) begin bad++; $display("FAIL err_idx prog written after error"); end
    total++; if (err !== 1'b1 || core_rst !== 1'b1) begin bad++; $display("FAIL err_idx sticky got err=%b core_rst=%b exp 1 1", err, core_rst); end
  endtask

  // Reserved bits [7:4] must not affect the length: 0x0010 is core 0, L=0.
  task automatic test_reserved();
    do_reset();
    push(16'h0010, 0);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reserved err got %b exp 0", err); end
    total++; if (loaded !== 12'h001) begin bad++; $display("FAIL reserved loaded got %h exp 001", loaded); end
    push(16'h00F2, 0); push(16'h0A0A, 0); push(16'h0B0B, 0);
    total++; if (prog_flat[0 +: 2*W] !== {16'h0B0B, 16'h0A0A} || plen_flat[3:0] !== 4'd2) begin bad++; $display("FAIL reserved core0 got %h plen %0d exp 0b0b0a0a plen 2", prog_flat[0 +: 2*W], plen_flat[3:0]); end
  endtask

  task automatic test_boundary();
    int d;
    do_reset();
    push(16'h0B0F, 0);
    for (int i = 0; i < PD; i++) push(W'($urandom), 0);
    total++; if (plen_flat[44 +: 4] !== 4'd15) begin bad++; $display("FAIL boundary plen11 got %0d exp 15", plen_flat[44 +: 4]); end
    total++; if (in_ready !== 1'b1 || core_rst !== 1'b1) begin bad++; $display("FAIL boundary back_to_hdr ready=%b core_rst=%b exp 1 1", in_ready, core_rst); end
    push(16'hFF00, 0);
    total++; d = prog_diff(); if (d >= 0) begin bad++; $display("FAIL boundary prog word %0d got %h exp %h", d, prog_flat[d*W +: W], m_prog[d/PD][d%PD]); end
    total++; if (loaded !== 12'h800) begin bad++; $display("FAIL boundary loaded got %h exp 800", loaded); end
  endtask

  task automatic test_stall();
    int d;
    logic [W-1:0] w1, w2, w3;
    w1 = W'($urandom); w2 = W'($urandom); w3 = W'($urandom);
    do_reset();
    push(16'h0303, 0); push(w1, 0);
    total++; if (prog_flat[(3*PD)*W +: W] !== w1) begin bad++; $display("FAIL stall slot0_latency got %h exp %h", prog_flat[(3*PD)*W +: W], w1); end
    repeat (5) begin @(negedge clk); in_valid = 1'b0; in_data = W'($urandom); end
    total++; d = prog_diff(); if (d >= 0) begin bad++; $display("FAIL stall during prog word %0d got %h exp %h", d, prog_flat[d*W +: W], m_prog[d/PD][d%PD]); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall in_ready got %b exp 1", in_ready); end
    push(w2, 0); push(w3, 0);
    total++; if (prog_flat[(3*PD)*W +: 3*W] !== {w3, w2, w1}) begin bad++; $display("FAIL stall slots got %h exp %h", prog_flat[(3*PD)*W +: 3*W], {w3, w2, w1}); end
    total++; d = prog_diff(); if (d >= 0) begin bad++; $display("FAIL stall after prog word %0d got %h exp %h", d, prog_flat[d*W +: W], m_prog[d/PD][d%PD]); end
  endtask

  task automatic test_mid_reset();
    int d;
    do_reset();
    push(16'h0403, 0); push(16'h4001, 0);
    do_reset();
    total++; if (prog_flat !== '0 || plen_flat !== '0 || loaded !== '0) begin bad++; $display("FAIL mid_reset state not cleared loaded=%h plen=%h", loaded, plen_flat); end
    total++; if (core_rst !== 1'b1 || err !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL mid_reset ctl got rst=%b err=%b rdy=%b exp 1 0 1", core_rst, err, in_ready); end
    push(16'h0403, 0); push(16'h4111, 0); push(16'h4222, 0); push(16'h4333, 0); push(16'hFF00, 0);
    total++; d = prog_diff(); if (d >= 0) begin bad++; $display("FAIL mid_reset prog word %0d got %h exp %h", d, prog_flat[d*W +: W], m_prog[d/PD][d%PD]); end
    total++; if (loaded !== 12'h010 || plen_flat !== exp_plen()) begin bad++; $display("FAIL mid_reset loaded/plen got %h/%h exp 010/%h", loaded, plen_flat, exp_plen()); end
    total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL mid_reset core_rst got %b exp 0", core_rst); end
  endtask

  task automatic test_random();
    int d, c, l, nf;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      nf = $urandom_range(3, 7);
      for (int f = 0; f < nf; f++) begin
        c = ($urandom_range(0, 7) == 0) ? $urandom_range(NC, 254) : $urandom_range(0, NC-1);
        l = $urandom_range(0, PD);
        push({8'(c), 4'($urandom), 4'(l)}, $urandom_range(0, 2));
        for (int i = 0; i < l; i++) push(W'($urandom), $urandom_range(0, 3));
        total++; d = prog_diff(); if (d >= 0) begin bad++; $display("FAIL random it%0d f%0d prog word %0d got %h exp %h", it, f, d, prog_flat[d*W +: W], m_prog[d/PD][d%PD]); end
        total++; if (plen_flat !== exp_plen()) begin bad++; $display("FAIL random it%0d f%0d plen got %h exp %h", it, f, plen_flat, exp_plen()); end
        total++; if (loaded !== m_loaded) begin bad++; $display("FAIL random it%0d f%0d loaded got %h exp %h", it, f, loaded, m_loaded); end
        total++; if (err !== m_err) begin bad++; $display("FAIL random it%0d f%0d err got %b exp %b", it, f, err, m_err); end
      end
      if ($urandom_range(0, 1) == 1) push(16'hFF00, 0);
      total++; if (core_rst !== !m_done) begin bad++; $display("FAIL random it%0d core_rst got %b exp %b", it, core_rst, !m_done); end
      total++; if (in_ready !== !(m_done || m_err)) begin bad++; $display("FAIL random it%0d in_ready got %b exp %b", it, in_ready, !(m_done || m_err)); end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_zero_len();
    test_reload();
    test_err_idx();
    test_reserved();
    test_boundary();
    test_stall();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
